// File: rtl/pe_float_pkg.sv
// Shared binary32 constants and sequencer state encoding for the PE float units.
package pe_float_pkg;

    localparam int F32_WIDTH  = 32;
    localparam int F32_EXP_W  = 8;
    localparam int F32_MANT_W = 23;
    localparam int F32_BIAS   = 127;

    localparam logic [31:0] F32_QNAN = 32'h7fc00000;
    localparam logic [31:0] F32_ONE  = 32'h3f800000;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        MULT,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/f32_norm_round.sv
// Packs sign, biased exponent and a 48-bit mantissa product into binary32,
// with round-to-nearest-even and saturation to inf or flush to zero.
module f32_norm_round (
    input  logic              sign,
    input  logic signed [9:0] exponent,
    input  logic [47:0]       prod,
    output logic [31:0]       result
);

    logic signed [9:0] e_adj;
    logic signed [9:0] e_fin;
    logic [22:0]       mant;
    logic              guard;
    logic              sticky;
    logic [23:0]       rounded;

    always_comb begin
        e_adj  = exponent;
        mant   = prod[45:23];
        guard  = prod[22];
        sticky = |prod[21:0];
        if (prod[47]) begin
            e_adj  = exponent + 10'sd1;
            mant   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
        end
        // A carry out of the rounded mantissa leaves its low bits zero.
        rounded = {1'b0, mant} + {23'd0, guard & (sticky | mant[0])};
        e_fin   = rounded[23] ? e_adj + 10'sd1 : e_adj;
        result  = {sign, e_fin[7:0], rounded[22:0]};
        if (e_fin >= 10'sd255) begin
            result = {sign, 8'hff, 23'd0};
        end else if (e_fin <= 10'sd0) begin
            result = {sign, 31'd0};
        end
    end

endmodule

// File: rtl/mult_seq_f32.sv
// Multi-cycle binary32 multiplier: unpack, 24-step shift-add mantissa
// multiply, then normalise and round. start/busy/rdy handshake.
module mult_seq_f32
    import pe_float_pkg::*;
#(
    parameter int WIDTH         = F32_WIDTH,
    parameter int EXPONENTWIDTH = F32_EXP_W,
    parameter int MANTISSAWIDTH = F32_MANT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             rdy,
    output logic [WIDTH-1:0] m
);

    state_t            state;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              sign;
    logic signed [9:0] exp_sum;
    logic [47:0]       mcand;
    logic [23:0]       mplier;
    logic [47:0]       acc;
    logic [4:0]        count;

    logic [EXPONENTWIDTH-1:0] ea, eb;
    logic [MANTISSAWIDTH-1:0] ma, mb;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic prod_sign;
    logic [31:0] norm_result;

    assign ea = a_reg[WIDTH-2 -: EXPONENTWIDTH];
    assign eb = b_reg[WIDTH-2 -: EXPONENTWIDTH];
    assign ma = a_reg[MANTISSAWIDTH-1:0];
    assign mb = b_reg[MANTISSAWIDTH-1:0];

    assign a_nan  = (&ea) & (|ma);
    assign b_nan  = (&eb) & (|mb);
    assign a_inf  = (&ea) & ~(|ma);
    assign b_inf  = (&eb) & ~(|mb);
    assign a_zero = ~(|ea);
    assign b_zero = ~(|eb);
    assign prod_sign = a_reg[WIDTH-1] ^ b_reg[WIDTH-1];

    f32_norm_round u_norm (
        .sign     (sign),
        .exponent (exp_sum),
        .prod     (acc),
        .result   (norm_result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            rdy     <= 1'b0;
            m       <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            sign    <= 1'b0;
            exp_sum <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        busy  <= 1'b1;
                        rdy   <= 1'b0;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign    <= prod_sign;
                    exp_sum <= {2'b00, ea} + {2'b00, eb} - 10'(F32_BIAS);
                    mcand   <= {24'd0, 1'b1, ma};
                    mplier  <= {1'b1, mb};
                    acc     <= '0;
                    count   <= '0;
                    // Special operands bypass the mantissa loop entirely.
                    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
                        m     <= F32_QNAN;
                        rdy   <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (a_inf | b_inf) begin
                        m     <= {prod_sign, 8'hff, 23'd0};
                        rdy   <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (a_zero | b_zero) begin
                        m     <= {prod_sign, 31'd0};
                        rdy   <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        state <= MULT;
                    end
                end
                MULT: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (count == 5'd23) begin
                        count <= '0;
                        state <= NORM;
                    end else begin
                        count <= count + 5'd1;
                    end
                end
                NORM: begin
                    m     <= norm_result;
                    rdy   <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_f32.sv
// Self-checking bench for mult_seq_f32: directed cases plus randomized
// operands checked against an integer-arithmetic binary32 reference.
module tb_mult_seq_f32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        rdy;
    logic [31:0] m;

    int checks = 0;
    int errors = 0;

    mult_seq_f32 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .rdy   (rdy),
        .m     (m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic bit isSpecial(input logic [31:0] x, input logic [31:0] y);
        return (x[30:23] == 8'hff) || (y[30:23] == 8'hff) || (x[30:23] == 8'h00) || (y[30:23] == 8'h00);
    endfunction

    // Reference product from field arithmetic on a full-width integer multiply.
    function automatic logic [31:0] refMul(input logic [31:0] x, input logic [31:0] y);
        logic            s;
        int              ex, ey, e, shift;
        longint unsigned mx, my, p, mant, rem, half;
        bit              xnan, ynan, xinf, yinf, xzero, yzero;
        s     = x[31] ^ y[31];
        ex    = int'(x[30:23]);
        ey    = int'(y[30:23]);
        xnan  = (ex == 255) && (x[22:0] != 0);
        ynan  = (ey == 255) && (y[22:0] != 0);
        xinf  = (ex == 255) && (x[22:0] == 0);
        yinf  = (ey == 255) && (y[22:0] == 0);
        xzero = (ex == 0);
        yzero = (ey == 0);
        if (xnan || ynan || (xinf && yzero) || (yinf && xzero)) return 32'h7fc00000;
        if (xinf || yinf) return {s, 8'hff, 23'd0};
        if (xzero || yzero) return {s, 31'd0};
        mx = 64'(x[22:0]) + (64'd1 << 23);
        my = 64'(y[22:0]) + (64'd1 << 23);
        p  = mx * my;
        e  = ex + ey - 127;
        if (p >= (64'd1 << 47)) begin
            shift = 24;
            e     = e + 1;
        end else begin
            shift = 23;
        end
        mant = (p >> shift) & 64'h7fffff;
        rem  = p & ((64'd1 << shift) - 1);
        half = 64'd1 << (shift - 1);
        if (rem > half || (rem == half && mant[0])) mant = mant + 1;
        if (mant == (64'd1 << 23)) begin
            mant = 0;
            e    = e + 1;
        end
        if (e >= 255) return {s, 8'hff, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), 23'(mant)};
    endfunction

    function automatic logic [31:0] genOperand();
        logic [7:0] e;
        int         pick;
        pick = int'($urandom_range(0, 9));
        if (pick == 0) return $urandom;
        if (pick == 1) e = 8'($urandom_range(1, 20));
        else if (pick == 2) e = 8'($urandom_range(230, 254));
        else e = 8'($urandom_range(80, 175));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic applyStimulus(input string tag, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        checkOutput({tag, "_busy_on"}, 32'(busy), 32'd1);
        checkOutput({tag, "_rdy_clr"}, 32'(rdy), 32'd0);
    endtask

    task automatic waitResult(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!rdy && cycles < 40);
    endtask

    task automatic runOp(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] expected, input int exp_lat);
        int c;
        applyStimulus(tag, x, y);
        waitResult(c);
        checkOutput({tag, "_latency"}, 32'(c), 32'(exp_lat));
        checkOutput({tag, "_m"}, m, expected);
        checkOutput({tag, "_busy_off"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int c;
        logic [31:0] x, y;
        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rdy", 32'(rdy), 32'd0);
        checkOutput("reset_m", m, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        runOp("two_x_three", 32'h40000000, 32'h40400000, 32'h40c00000, 26);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold_rdy", 32'(rdy), 32'd1);
        checkOutput("hold_m", m, 32'h40c00000);

        runOp("neg_mul", 32'hbfc00000, 32'h40200000, 32'hc0700000, 26);
        runOp("zero_x_inf", 32'h00000000, 32'h7f800000, 32'h7fc00000, 1);
        runOp("ninf_x_two", 32'hff800000, 32'h40000000, 32'hff800000, 1);
        runOp("nan_in", 32'h7fc00001, 32'h3f800000, 32'h7fc00000, 1);
        runOp("overflow", 32'h7f000000, 32'h40000000, 32'h7f800000, 26);
        runOp("underflow", 32'h00800000, 32'h3f000000, 32'h00000000, 26);
        runOp("rne", 32'h3f800001, 32'h3f800001, 32'h3f800002, 26);
        runOp("denorm_flush", 32'h80000001, 32'h3f800000, 32'h80000000, 1);

        // A start pulse while busy must not disturb the captured operands.
        applyStimulus("busy_ign", 32'h3fc00000, 32'h40400000);
        repeat (4) @(posedge clk);
        @(negedge clk);
        a     = 32'h40000000;
        b     = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_ign_still_busy", 32'(busy), 32'd1);
        waitResult(c);
        checkOutput("busy_ign_latency", 32'(c + 5), 32'd26);
        checkOutput("busy_ign_m", m, 32'h40900000);

        // Reset in the middle of an operation.
        applyStimulus("rst_mid", 32'h40000000, 32'h40400000);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_rdy", 32'(rdy), 32'd0);
        checkOutput("rst_mid_m", m, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        runOp("after_rst", 32'h40000000, 32'h40400000, 32'h40c00000, 26);

        for (int i = 0; i < 40; i++) begin
            x = genOperand();
            y = genOperand();
            runOp($sformatf("rand%0d", i), x, y, refMul(x, y), isSpecial(x, y) ? 1 : 26);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
